// File: rtl/rv_multicycle_ctrl_if.sv
// Instruction-memory fetch channel between the multicycle sequencer and the imem.
// The sequencer holds imem_req until imem_ack; imem_addr tracks the current PC.
interface rv_multicycle_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer: owns the instruction register, PC update,
// register-file write enable, retire counting and sticky error trapping.
module rv_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    rv_multicycle_ctrl_if.master         imem,
    output logic [31:0]                  komut,
    input  logic [6:0]                   opcode,
    input  logic [4:0]                   rd,
    input  logic [31:0]                  imm,
    input  logic                         hata,
    input  logic                         br_taken,
    output logic                         alu_en,
    output logic                         we,
    output logic                         wb_sel,
    output logic [31:0]                  pc,
    output logic                         retire,
    output logic [31:0]                  instr_count,
    output logic                         trap,
    output logic [1:0]                   trap_cause
);
    localparam int unsigned CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WB, TRAP
    } state_t;

    state_t        state;
    logic [CW-1:0] tmo;
    logic [31:0]   next_pc;
    logic [31:0]   target;
    logic          take;
    logic          writes_rd;

    always_comb begin
        take      = ((opcode == 7'h63) && br_taken) || (opcode == 7'h6F);
        target    = take ? (pc + imm) : (pc + 32'd4);
        writes_rd = ((opcode == 7'h33) || (opcode == 7'h13) ||
                     (opcode == 7'h37) || (opcode == 7'h6F)) && (rd != 5'd0);
    end

    assign imem.imem_addr = pc;

    // Pulse-style outputs default low each cycle and are set on the transition
    // into the state in which they must be visible, so they read as decoded from state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tmo           <= '0;
            next_pc       <= '0;
            pc            <= RESET_PC;
            komut         <= '0;
            imem.imem_req <= 1'b0;
            alu_en        <= 1'b0;
            we            <= 1'b0;
            wb_sel        <= 1'b0;
            retire        <= 1'b0;
            instr_count   <= '0;
            trap          <= 1'b0;
            trap_cause    <= '0;
        end else begin
            imem.imem_req <= 1'b0;
            alu_en        <= 1'b0;
            we            <= 1'b0;
            wb_sel        <= 1'b0;
            retire        <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state         <= FETCH;
                        imem.imem_req <= 1'b1;
                        tmo           <= '0;
                    end
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        komut <= imem.imem_rdata;
                        state <= DECODE;
                    end else if (tmo == TMO_LAST) begin
                        state      <= TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b10;
                    end else begin
                        tmo           <= tmo + CW'(1);
                        imem.imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    if (hata) begin
                        state      <= TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                    end else begin
                        state  <= EXEC;
                        alu_en <= 1'b1;
                    end
                end
                EXEC: begin
                    if (target[1:0] != 2'b00) begin
                        state      <= TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b11;
                    end else begin
                        next_pc <= target;
                        state   <= WB;
                        we      <= writes_rd;
                        wb_sel  <= (opcode == 7'h6F);
                        retire  <= 1'b1;
                    end
                end
                WB: begin
                    pc          <= next_pc;
                    instr_count <= instr_count + 32'd1;
                    if (run) begin
                        state         <= FETCH;
                        imem.imem_req <= 1'b1;
                        tmo           <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: a table of single-instruction vectors plus
// hand-written sequences for fetch timeout, trap stickiness and async reset mid-EXEC.
module tb_rv_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [31:0] komut;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [31:0] imm = '0;
    logic        hata = 1'b0;
    logic        br_taken = 1'b0;
    logic        alu_en, we, wb_sel, retire, trap;
    logic [31:0] pc, instr_count;
    logic [1:0]  trap_cause;

    int total = 0;
    int bad = 0;

    rv_multicycle_ctrl_if bus ();

    rv_multicycle_ctrl #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .run(run), .imem(bus.master),
        .komut(komut), .opcode(opcode), .rd(rd), .imm(imm), .hata(hata), .br_taken(br_taken),
        .alu_en(alu_en), .we(we), .wb_sel(wb_sel), .pc(pc), .retire(retire),
        .instr_count(instr_count), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [31:0] rdata;
        logic [6:0]  opc;
        logic [4:0]  rdv;
        logic [31:0] immv;
        bit          br;
        bit          ill;
        bit          exp_we;
        bit          exp_wbs;
        logic [31:0] exp_pc;
        bit          exp_trap;
        logic [1:0]  exp_cause;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    int we_n, we_at, ret_n, wbs_seen;

    task automatic sample(input int k);
        if (we === 1'b1) begin
            we_n++;
            we_at = k;
        end
        if (wb_sel === 1'b1) wbs_seen = 1;
        if (retire === 1'b1) ret_n++;
    endtask

    // One instruction from IDLE with ack in the first FETCH cycle, then back to IDLE.
    task automatic run_one(input vec_t v);
        opcode = v.opc; rd = v.rdv; imm = v.immv; br_taken = v.br; hata = v.ill;
        bus.imem_rdata = v.rdata;
        bus.imem_ack   = 1'b1;
        run = 1'b1;
        we_n = 0; we_at = 0; ret_n = 0; wbs_seen = 0;
        @(posedge clk); #1;
        sample(1);
        run = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk); #1;
            sample(k);
        end
    endtask

    initial begin
        int req_n;
        bit got_trap;

        //            rst rdata          opc    rd  imm            br ill we wbs pc             trap cause cnt
        vecs[0]  = '{1, 32'h0050_0093, 7'h13, 5'd1, 32'd5,          0, 0, 1, 0, 32'h0000_0004, 0, 2'b00, 32'd1};
        vecs[1]  = '{1, 32'h0000_FB01, 7'h01, 5'd0, 32'd0,          0, 1, 0, 0, 32'h0000_0000, 1, 2'b01, 32'd0};
        vecs[2]  = '{1, 32'h0000_0013, 7'h13, 5'd0, 32'd0,          0, 0, 0, 0, 32'h0000_0004, 0, 2'b00, 32'd1};
        vecs[3]  = '{0, 32'h0070_2023, 7'h23, 5'd7, 32'd0,          0, 0, 0, 0, 32'h0000_0008, 0, 2'b00, 32'd2};
        vecs[4]  = '{0, 32'hFE00_0CE3, 7'h63, 5'd0, 32'hFFFF_FFF8,  1, 0, 0, 0, 32'h0000_0000, 0, 2'b00, 32'd3};
        vecs[5]  = '{0, 32'h1234_51B7, 7'h37, 5'd3, 32'h1234_5000,  0, 0, 1, 0, 32'h0000_0004, 0, 2'b00, 32'd4};
        vecs[6]  = '{0, 32'h0020_82B3, 7'h33, 5'd5, 32'd0,          1, 0, 1, 0, 32'h0000_0008, 0, 2'b00, 32'd5};
        vecs[7]  = '{0, 32'hFE00_0CE3, 7'h63, 5'd0, 32'hFFFF_FFF8,  0, 0, 0, 0, 32'h0000_000C, 0, 2'b00, 32'd6};
        vecs[8]  = '{0, 32'h0000_0263, 7'h63, 5'd0, 32'd4,          1, 0, 0, 0, 32'h0000_0010, 0, 2'b00, 32'd7};
        vecs[9]  = '{0, 32'h0200_00EF, 7'h6F, 5'd1, 32'h0000_0020,  0, 0, 1, 1, 32'h0000_0030, 0, 2'b00, 32'd8};
        vecs[10] = '{0, 32'hFE1F_F06F, 7'h6F, 5'd0, 32'hFFFF_FFE0,  0, 0, 0, 1, 32'h0000_0010, 0, 2'b00, 32'd9};
        vecs[11] = '{0, 32'h0220_00EF, 7'h6F, 5'd1, 32'h0000_0022,  0, 0, 0, 0, 32'h0000_0010, 1, 2'b11, 32'd9};
        vecs[12] = '{1, 32'hFFDF_F06F, 7'h6F, 5'd0, 32'hFFFF_FFFC,  0, 0, 0, 1, 32'hFFFF_FFFC, 0, 2'b00, 32'd1};
        vecs[13] = '{0, 32'h0010_0113, 7'h13, 5'd2, 32'd1,          0, 0, 1, 0, 32'h0000_0000, 0, 2'b00, 32'd2};

        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        do_reset();
        chk("reset pc", pc, 32'h0);
        chk("reset komut", komut, 32'h0);
        chk("reset count", instr_count, 32'h0);
        chk("reset flags", {29'd0, trap, bus.imem_req, we}, 32'h0);
        chk("reset cause", {30'd0, trap_cause}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) do_reset();
            run_one(vecs[i]);
            chk($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d we_pulses", i), we_n, {31'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) chk($sformatf("v%0d we_cycle", i), we_at, 32'd4);
            chk($sformatf("v%0d wb_sel", i), wbs_seen, {31'd0, vecs[i].exp_wbs});
            chk($sformatf("v%0d retire", i), ret_n, {31'd0, !vecs[i].exp_trap});
            chk($sformatf("v%0d trap", i), {31'd0, trap}, {31'd0, vecs[i].exp_trap});
            chk($sformatf("v%0d cause", i), {30'd0, trap_cause}, {30'd0, vecs[i].exp_cause});
            chk($sformatf("v%0d count", i), instr_count, vecs[i].exp_cnt);
            chk($sformatf("v%0d komut", i), komut, vecs[i].rdata);
        end

        // Fetch timeout: no ack, request must stay up for exactly 16 cycles.
        do_reset();
        hata = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        run = 1'b1;
        req_n = 0;
        got_trap = 1'b0;
        for (int k = 0; k < 40 && !got_trap; k++) begin
            @(posedge clk); #1;
            if (bus.imem_req === 1'b1) req_n++;
            if (trap === 1'b1) got_trap = 1'b1;
        end
        chk("tmo reached", {31'd0, got_trap}, 32'd1);
        chk("tmo req_cycles", req_n, 32'd16);
        chk("tmo cause", {30'd0, trap_cause}, 32'h2);
        chk("tmo req_drop", {31'd0, bus.imem_req}, 32'd0);
        chk("tmo addr", bus.imem_addr, 32'h0);

        // Trap is sticky: late ack and run are ignored.
        bus.imem_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sticky trap", {31'd0, trap}, 32'd1);
        chk("sticky komut", komut, 32'h0);
        chk("sticky req", {31'd0, bus.imem_req}, 32'd0);
        chk("sticky pc", pc, 32'h0);

        // Async reset while in EXEC.
        do_reset();
        run_one(vecs[0]);
        chk("pre pc", pc, 32'h4);
        opcode = 7'h13; rd = 5'd1; imm = 32'd5; br_taken = 1'b0; hata = 1'b0;
        bus.imem_ack = 1'b1;
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run = 1'b0;
        chk("exec alu_en", {31'd0, alu_en}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async pc", pc, 32'h0);
        chk("async komut", komut, 32'h0);
        chk("async count", instr_count, 32'h0);
        chk("async alu_en", {31'd0, alu_en}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post reset we", {31'd0, we}, 32'd0);
        chk("post reset pc", pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
